// File: rtl/aes_pkg.sv
// Shared types and constants for the AES state loader and its slot store.
//   aes_state_t  : full 128-bit state, indexed [column][row][bit]
//   aes_word_t   : one 32-bit column word, bits [8r+7:8r] hold row r
//   aes_slot_t   : one buffered state plus the op bit that travels with it
//   slot_state_e : lifecycle of a single buffer slot
package aes_pkg;

  localparam int NumColumns = 4;
  localparam int NumRows    = 4;

  typedef logic [NumColumns-1:0][NumRows-1:0][7:0] aes_state_t;
  typedef logic [31:0] aes_word_t;

  typedef struct packed {
    logic       op;
    aes_state_t state;
  } aes_slot_t;

  typedef enum logic [1:0] {
    SlotEmpty,
    SlotFilling,
    SlotFull
  } slot_state_e;

endpackage

// File: rtl/aes_state_slot.sv
// Single state buffer slot: one column register per column with its own
// write enable, plus the op bit captured on the first beat.
//   clk, rst : clock and synchronous active-high reset
//   col_we   : one-hot column write enable
//   op_we    : capture op alongside column 0
//   word     : column word to write
//   op       : op bit to capture
//   slot     : stored op bit and state
module aes_state_slot
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumColumns-1:0] col_we,
  input  logic                  op_we,
  input  aes_word_t             word,
  input  logic                  op,
  output aes_slot_t             slot
);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else begin
      for (int c = 0; c < NumColumns; c++) begin
        if (col_we[c]) slot.state[c] <= word;
      end
      if (op_we) slot.op <= op;
    end
  end

endmodule

// File: rtl/aes_state_loader.sv
// Collects four 32-bit column words into a 128-bit AES state and buffers
// complete states in a small ring of slots ahead of the SubBytes stage.
//   clk, rst      : clock and synchronous active-high reset
//   clear_i       : flush partial state (and full slots unless ClearKeepsFull)
//   in_valid_i    : column word valid
//   in_ready_o    : a word can be accepted this cycle
//   in_word_i     : column word, row r in bits [8r+7:8r]
//   in_op_i       : op bit, sampled on beat 0 only
//   out_valid_o   : a complete state is presented
//   out_ready_i   : downstream takes the presented state
//   op_o, data_o  : presented op bit and state
//   busy_o        : a state is being assembled or any slot is full
module aes_state_loader
  import aes_pkg::*;
#(
  parameter int NumSlots       = 2,
  parameter bit ClearKeepsFull = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  aes_word_t  in_word_i,
  input  logic       in_op_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       op_o,
  output aes_state_t data_o,
  output logic       busy_o
);

  localparam int PtrW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam logic [PtrW-1:0] LastSlot = PtrW'(NumSlots - 1);

  logic [1:0]          beat_q, beat_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  slot_state_e         slot_state_q [NumSlots];
  slot_state_e         slot_state_d [NumSlots];
  logic [NumSlots-1:0] full;
  aes_slot_t           slot_q [NumSlots];
  logic                in_fire;
  logic                out_fire;

  always_comb begin
    for (int i = 0; i < NumSlots; i++) begin
      full[i] = (slot_state_q[i] == SlotFull);
    end
  end

  // in_ready_o depends only on registered flags, so a drain this cycle
  // frees the slot for input no earlier than the next cycle.
  assign in_ready_o  = !full[wr_ptr_q];
  assign out_valid_o = full[rd_ptr_q];
  assign data_o      = slot_q[rd_ptr_q].state;
  assign op_o        = slot_q[rd_ptr_q].op;
  assign busy_o      = (beat_q != 2'd0) || (|full);

  // Clear overrides both handshakes in the same cycle.
  assign in_fire  = in_valid_i && in_ready_o && !clear_i;
  assign out_fire = out_valid_o && out_ready_i && !clear_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < NumSlots; i++) slot_state_q[i] <= SlotEmpty;
    end else begin
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < NumSlots; i++) slot_state_q[i] <= slot_state_d[i];
    end
  end

  // The write slot is never full while accepting, and the read slot is
  // always full while draining, so both updates can land together.
  always_comb begin
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < NumSlots; i++) slot_state_d[i] = slot_state_q[i];

    if (clear_i) begin
      beat_d = '0;
      for (int i = 0; i < NumSlots; i++) begin
        if (!ClearKeepsFull || slot_state_q[i] == SlotFilling) slot_state_d[i] = SlotEmpty;
      end
      if (!ClearKeepsFull) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
    end else begin
      if (out_fire) begin
        slot_state_d[rd_ptr_q] = SlotEmpty;
        rd_ptr_d = (rd_ptr_q == LastSlot) ? '0 : rd_ptr_q + 1'b1;
      end
      if (in_fire) begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd0) slot_state_d[wr_ptr_q] = SlotFilling;
        if (beat_q == 2'd3) begin
          slot_state_d[wr_ptr_q] = SlotFull;
          wr_ptr_d = (wr_ptr_q == LastSlot) ? '0 : wr_ptr_q + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NumSlots; g++) begin : g_slot
    logic sel;
    assign sel = in_fire && (wr_ptr_q == PtrW'(g));

    aes_state_slot u_slot (
      .clk    (clk),
      .rst    (rst),
      .col_we (sel ? (4'b0001 << beat_q) : 4'b0000),
      .op_we  (sel && (beat_q == 2'd0)),
      .word   (in_word_i),
      .op     (in_op_i),
      .slot   (slot_q[g])
    );
  end

endmodule

// File: tb/tb_aes_state_loader.sv
// Bench for aes_state_loader: two instances (flush-all and keep-full clear)
// driven with shared stimulus and compared every cycle against a
// queue-based reference model of buffered states.
module tb_aes_state_loader;
  import aes_pkg::*;

  localparam int NSlots = 2;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      clear = 1'b0;
  logic      in_valid = 1'b0;
  logic      in_op = 1'b0;
  logic      out_ready = 1'b0;
  aes_word_t in_word = '0;

  logic       in_ready  [2];
  logic       out_valid [2];
  logic       op        [2];
  logic       busy      [2];
  aes_state_t data      [2];

  typedef struct packed {
    logic         op;
    logic [127:0] state;
  } rec_t;

  rec_t        mq [2][$];
  logic [31:0] pw [2][4];
  int          pcnt [2];
  logic        pop [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aes_state_loader #(.NumSlots(NSlots), .ClearKeepsFull(1'b0)) dut (
    .clk(clk), .rst(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .in_word_i(in_word), .in_op_i(in_op),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .op_o(op[0]), .data_o(data[0]),
    .busy_o(busy[0])
  );

  aes_state_loader #(.NumSlots(NSlots), .ClearKeepsFull(1'b1)) dut_keep (
    .clk(clk), .rst(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .in_word_i(in_word), .in_op_i(in_op),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .op_o(op[1]), .data_o(data[1]),
    .busy_o(busy[1])
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a FIFO of finished states (capacity NSlots) and a partial
  // word buffer. Readiness is decided from the occupancy before the edge.
  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mq[i].delete();
        pcnt[i] = 0;
      end else if (clear) begin
        pcnt[i] = 0;
        if (i == 0) mq[i].delete();
      end else begin
        bit   room;
        rec_t r;
        room = mq[i].size() < NSlots;
        if (out_ready && mq[i].size() > 0) void'(mq[i].pop_front());
        if (in_valid && room) begin
          pw[i][pcnt[i]] = in_word;
          if (pcnt[i] == 0) pop[i] = in_op;
          pcnt[i]++;
          if (pcnt[i] == 4) begin
            r.op    = pop[i];
            r.state = {pw[i][3], pw[i][2], pw[i][1], pw[i][0]};
            mq[i].push_back(r);
            pcnt[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("in_ready%0d", i), 128'(in_ready[i]), 128'(mq[i].size() < NSlots));
      checkOutput($sformatf("out_valid%0d", i), 128'(out_valid[i]), 128'(mq[i].size() > 0));
      checkOutput($sformatf("busy%0d", i), 128'(busy[i]), 128'((pcnt[i] != 0) || (mq[i].size() > 0)));
      if (mq[i].size() > 0) begin
        checkOutput($sformatf("data%0d", i), data[i], mq[i][0].state);
        checkOutput($sformatf("op%0d", i), 128'(op[i]), 128'(mq[i][0].op));
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] w,
                               input logic o, input logic rdy, input logic clr);
    rst       = r;
    in_valid  = v;
    in_word   = w;
    in_op     = o;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  // Op is driven to its complement on beats 1-3 so that only beat 0 counts.
  task automatic loadState(input logic [127:0] words, input logic o, input logic rdy);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, words[32*k +: 32], (k == 0) ? o : ~o, rdy, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  localparam logic [127:0] StateA = 128'h4C31262D_01010101_5C220AF2_455313DB;
  localparam logic [127:0] StateB = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] StateC = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] StateE = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] StateF = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

  initial begin
    for (int i = 0; i < 2; i++) pcnt[i] = 0;

    // Reset and quiet state
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    checkOutput("reset_data0", data[0], 128'h0);
    checkOutput("reset_ready0", 128'(in_ready[0]), 128'h1);
    checkOutput("reset_valid0", 128'(out_valid[0]), 128'h0);
    checkOutput("reset_data1", data[1], 128'h0);

    // Single state, presented one cycle after beat 3
    loadState(StateA, 1'b0, 1'b1);
    checkOutput("single_valid", 128'(out_valid[0]), 128'h1);
    checkOutput("single_data", data[0], StateA);
    idle(2, 1'b1);

    // Backpressure: two states fill both slots, ninth word refused
    loadState(StateB, 1'b0, 1'b0);
    loadState(StateC, 1'b1, 1'b0);
    checkOutput("full_ready", 128'(in_ready[0]), 128'h0);
    applyStimulus(1'b0, 1'b1, 32'h99999999, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("ready_after_drain", 128'(in_ready[0]), 128'h1);
    checkOutput("second_op", 128'(op[0]), 128'h1);
    idle(2, 1'b1);

    // Op sampled on beat 0 only
    loadState(StateE, 1'b1, 1'b0);
    checkOutput("op_sample", 128'(op[0]), 128'h1);
    idle(2, 1'b1);

    // Clear during beat 2 of the second state, first state full
    loadState(StateC, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h01020304, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h05060708, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h090A0B0C, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_valid0", 128'(out_valid[0]), 128'h0);
    checkOutput("clear_busy0", 128'(busy[0]), 128'h0);
    checkOutput("clear_keep_valid1", 128'(out_valid[1]), 128'h1);
    checkOutput("clear_keep_data1", data[1], StateC);
    loadState(StateE, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Reset in the middle of a state, then a fresh state
    applyStimulus(1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hBAD1BAD1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    loadState(StateF, 1'b0, 1'b0);
    checkOutput("after_reset_data", data[0], StateF);
    checkOutput("after_reset_data_keep", data[1], StateF);
    idle(2, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(($urandom_range(0, 300) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                    $urandom,
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_state_loader.md
Name: aes_state_loader

Overview:
- Upstream feeder for aes_sub_bytes.
- Assembles a 128-bit AES state from four 32-bit column words received over a valid/ready bus.
- Buffers complete states in a ping-pong slot store and presents one state plus its op bit to the SubBytes stage over a valid/ready handshake.
- Decouples the narrow key/data interface from the full-width round datapath, so the next block can be collected while the previous one stalls.

Parameters:
- NumSlots, 2, number of complete-state buffer slots; legal values 1, 2, 4.
- ClearKeepsFull, 0, when 1 clear_i drops only the partial state and keeps full slots.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- clear_i  input  1  synchronous flush (see Behaviour).
- in_valid_i  input  1  column word valid.
- in_ready_o  output  1  loader can accept a word this cycle.
- in_word_i  input  32  column word; bits [8r+7:8r] are row r.
- in_op_i  input  1  0 = forward (cipher), 1 = inverse; sampled on beat 0 only.
- out_valid_o  output  1  a complete state is presented.
- out_ready_i  input  1  downstream accepts the state.
- op_o  output  1  op bit of the presented state; feeds aes_sub_bytes op_i.
- data_o  output  [3:0][3:0][7:0]  presented state; data_o[c][r] = byte r of column c.
- busy_o  output  1  any slot partial or full.

Behaviour:
- Reset values: in_ready_o=1, out_valid_o=0, op_o=0, data_o=0, busy_o=0. Beat counter, write pointer, read pointer and all full flags are cleared.
- An input beat is accepted when in_valid_i && in_ready_o.
- Beat k (k=0..3) writes in_word_i to slot[wr_ptr].data[k]. On beat 0, in_op_i is captured into slot[wr_ptr].op. in_op_i on beats 1-3 is ignored.
- Beat counter: 2 bits, wraps 3->0.
- On beat 3: full[wr_ptr] is set and wr_ptr increments, modulo NumSlots.
- Per-slot state machine:
  - EMPTY -> FILLING on beat 0.
  - FILLING -> FULL on beat 3.
  - FULL -> EMPTY on output handshake.
- in_ready_o = !full[wr_ptr], taken from registered state only. There is no combinational path from out_ready_i to in_ready_o.
- out_valid_o = full[rd_ptr]. data_o and op_o are driven from slot[rd_ptr]. data_o must be stable while out_valid_o && !out_ready_i.
- Output handshake (out_valid_o && out_ready_i): full[rd_ptr] clears and rd_ptr increments.
- Latency:
  - Beat 3 accepted in cycle N -> out_valid_o=1 in cycle N+1 (NumSlots≥1, output side idle).
  - Back-to-back input sustains one state per 4 cycles with out_ready_i held at 1.
- Simultaneous events:
  - Output handshake on slot A and input beat on slot B in the same cycle: both take effect.
  - All slots full with an output handshake in cycle N: in_ready_o rises in cycle N+1, never in cycle N.
  - NumSlots=1: the slot cannot be refilled in the cycle it drains. in_ready_o rises the following cycle.
- Clear:
  - clear_i=1 has priority over same-cycle input and output handshakes.
  - It resets the beat counter and discards the partial slot.
  - With ClearKeepsFull=0 it also clears all full flags and resets both pointers to 0, so out_valid_o=0 in the next cycle.
  - With ClearKeepsFull=1, full slots, rd_ptr and wr_ptr are kept. The partial slot is reused from beat 0.
- Reset mid-operation: identical to reset. The in-flight partial and the full states are lost.
- busy_o = (beat counter != 0) || any full flag.

Decomposition:
- Shared package aes_pkg holds:
  - the state typedef (logic [3:0][3:0][7:0]);
  - the column word typedef (logic [31:0]);
  - constants NumColumns=4 and NumRows=4;
  - the slot struct {op, state}.
- One sub-module, aes_state_slot: a single slot register with per-column write enables and op capture. It is instantiated NumSlots times.
- Pointers, beat counter and handshake logic stay in the top level.

Test Plan:
1. After reset, with no stimulus: in_ready_o=1, out_valid_o=0, data_o=0.
2. Single state, out_ready_i=1:
   - Stimulus: op=0; words 0x455313DB, 0x5C220AF2, 0x01010101, 0x4C31262D.
   - Response: out_valid_o exactly one cycle after beat 3.
   - data_o[3]={76,49,38,45}, data_o[2]={1,1,1,1}, data_o[1]={92,34,10,242}, data_o[0]={69,83,19,219}.
   - Downstream aes_sub_bytes yields data_o[3]={41,199,247,216}, data_o[2]={124,124,124,124}.
3. Backpressure, NumSlots=2, out_ready_i=0:
   - Load two states (op=0, then op=1). in_ready_o falls after the 8th beat. A 9th word is not accepted.
   - Raise out_ready_i: first state with op_o=0, then second with op_o=1. data_o is stable throughout the stall.
   - in_ready_o returns to 1 one cycle after the first drain.
4. Op sampling: load words with in_op_i=1 on beat 0 and 0 on beats 1-3 -> op_o=1.
5. Clear during beat 2 of the second state with the first state full:
   - ClearKeepsFull=0 -> out_valid_o=0 next cycle, busy_o=0.
   - ClearKeepsFull=1 -> the first state is still presented, and the next four words form a fresh state.
6. Reset asserted mid-state (after beat 1), then a complete new state -> output contains only the new words. No stale columns remain.
